// File: rtl/pc_predictor.sv
// IF-stage PC register with a direct-mapped BTB and 2-bit direction counters.
// Define PC_PRED_BTB_EN to build the BTB; without it the predictor always falls through to pc+4.
module pc_predictor #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            cpu_clk,
  input  logic            cpu_rstn,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pred_npc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] ex_pc_plus4;

  assign pc_plus4    = pc + XLEN'(4);
  assign ex_pc_plus4 = ex_pc + XLEN'(4);
  assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc_plus4;

`ifdef PC_PRED_BTB_EN
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags [ENTRIES];
  logic [XLEN-1:0]    tgts [ENTRIES];
  logic [1:0]         ctrs [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] x_idx;
  logic [TAG_W-1:0] x_tag;
  logic             x_hit;

  // Fetch-side lookup reads the pre-write contents of the arrays.
  assign f_idx = pc[IDX_W+1:2];
  assign f_tag = pc[XLEN-1:IDX_W+2];
  assign f_hit = valid[f_idx] && (tags[f_idx] == f_tag);

  assign x_idx = ex_pc[IDX_W+1:2];
  assign x_tag = ex_pc[XLEN-1:IDX_W+2];
  assign x_hit = valid[x_idx] && (tags[x_idx] == x_tag);

  assign pred_taken = f_hit && ctrs[f_idx][1];
  assign pred_npc   = pred_taken ? tgts[f_idx] : pc_plus4;

  assign redirect = ex_valid &&
                    ((ex_is_branch && ((ex_taken != ex_pred_taken) ||
                                       (ex_taken && (ex_target != ex_pred_target)))) ||
                     (!ex_is_branch && ex_pred_taken));

  // Training from the resolved EX instruction; independent of stall.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      valid <= '0;
      tags  <= '{default: '0};
      tgts  <= '{default: '0};
      ctrs  <= '{default: 2'b01};
    end else if (ex_valid) begin
      if (ex_is_branch) begin
        if (x_hit) begin
          if (ex_taken) begin
            if (ctrs[x_idx] != 2'b11) ctrs[x_idx] <= ctrs[x_idx] + 2'd1;
            tgts[x_idx] <= ex_target;
          end else if (ctrs[x_idx] != 2'b00) begin
            ctrs[x_idx] <= ctrs[x_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid[x_idx] <= 1'b1;
          tags[x_idx]  <= x_tag;
          tgts[x_idx]  <= ex_target;
          ctrs[x_idx]  <= 2'b10;
        end
      end else if (ex_pred_taken && (tags[x_idx] == x_tag)) begin
        // A non-branch was predicted taken: the entry aliased onto it.
        valid[x_idx] <= 1'b0;
      end
    end
  end
`else
  logic unused_pred_target;

  assign unused_pred_target = ^ex_pred_target;
  assign pred_taken         = 1'b0;
  assign pred_npc           = pc_plus4;
  // Nothing is ever predicted taken here, so every taken branch redirects.
  assign redirect = ex_valid &&
                    ((ex_is_branch && (ex_taken || ex_pred_taken)) ||
                     (!ex_is_branch && ex_pred_taken));
`endif

  // PC register: redirect beats stall, stall beats prediction.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= pred_npc;
    end
  end

endmodule

// File: doc/pc_predictor.md
PC_PREDICTOR -- requirements
Module: pc_predictor

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter ENTRIES, default 16, number of BTB entries; power of two, 2..256.
REQ-003 Parameter RESET_PC, default 32'h0, PC value loaded on reset.
REQ-004 cpu_clk  in  1  single clock; all state updates on rising edge.
REQ-005 cpu_rstn  in  1  reset, asynchronous, active-low.
REQ-006 stall  in  1  hazard stall; hold PC.
REQ-007 pc  out  XLEN  current IF-stage PC (registered).
REQ-008 pred_npc  out  XLEN  predicted next PC (combinational from pc).
REQ-009 pred_taken  out  1  prediction for instruction at pc; travels down the pipe with that instruction.
REQ-010 ex_valid  in  1  EX-stage instruction valid (not a bubble).
REQ-011 ex_is_branch  in  1  EX instruction is a branch, jal or jalr.
REQ-012 ex_pc, ex_target  in  XLEN each  EX instruction PC; resolved target, already aligned.
REQ-013 ex_taken  in  1  resolved direction.
REQ-014 ex_pred_taken, ex_pred_target  in  1, XLEN  prediction carried with the EX instruction.
REQ-015 redirect  out  1  mispredict; pipeline flushes IF/ID and ID/EX.
REQ-016 redirect_pc  out  XLEN  correct fetch address when redirect=1.

Function
REQ-017 Index = pc[log2(ENTRIES)+1:2]; tag = pc[XLEN-1:log2(ENTRIES)+2]; each entry holds valid, tag, target, 2-bit counter.
REQ-018 Hit = valid and tag match at indexed entry; pred_taken = hit and counter[1]; pred_npc = pred_taken ? entry target : pc+4 (modulo 2^XLEN).
REQ-019 redirect = ex_valid and (ex_is_branch and (ex_taken != ex_pred_taken or (ex_taken and ex_target != ex_pred_target))) or (not ex_is_branch and ex_pred_taken)); combinational, same cycle.
REQ-020 redirect_pc = (ex_is_branch and ex_taken) ? ex_target : ex_pc+4.
REQ-021 PC update priority per edge: redirect -> pc <= redirect_pc (overrides stall); else stall -> hold; else pc <= pred_npc.
REQ-022 Update when ex_valid and ex_is_branch, on hit at ex_pc: counter saturating +1 if taken, -1 if not (range 00..11); target <= ex_target if taken.
REQ-023 Update on miss: taken -> allocate/overwrite entry: valid=1, tag, target, counter=10; not-taken -> no change.
REQ-024 ex_valid, not ex_is_branch, ex_pred_taken (alias): invalidate indexed entry if tag matches.
REQ-025 Updates occur regardless of stall; lookup in the same cycle as a write to the same index sees pre-write contents.
REQ-026 No update when ex_valid=0.

Reset
REQ-027 While cpu_rstn=0: pc=RESET_PC, all valid bits=0, counters=01, targets and tags=0; pred_taken=0, pred_npc=RESET_PC+4.
REQ-028 Reset asserted mid-operation discards all prediction state immediately; first edge after deassertion fetches RESET_PC+4 unless stall or redirect.

Configuration
REQ-029 Macro PC_PRED_BTB_EN defined: BTB behaviour per REQ-017..REQ-026.
REQ-030 Macro PC_PRED_BTB_EN undefined: no BTB storage; pred_taken=0, pred_npc=pc+4; redirect for every taken branch; REQ-021 unchanged.

Verification
REQ-031 Reset, no stall, ex_valid=0 for 4 cycles -> pc 0x0,0x4,0x8,0xC,0x10; redirect=0.
REQ-032 Taken branch at ex_pc=0x20, target 0x100, ex_pred_taken=0 -> redirect=1, redirect_pc=0x100, pc=0x100 next edge; a later fetch at 0x20 gives pred_taken=1, pred_npc=0x100.
REQ-033 Same branch resolved not-taken twice after allocation -> counter 10->01->00; first not-taken raises redirect with redirect_pc=0x24; next fetch at 0x20 gives pred_npc=0x24.
REQ-034 stall=1 and redirect=1 in same cycle -> pc loads redirect_pc; stall=1 alone holds pc for 3 cycles.
REQ-035 Aliasing: 0x20 allocated; non-branch at 0x20 with ex_pred_taken=1 -> redirect_pc=0x24, entry invalidated, next lookup at 0x20 misses.
REQ-036 Build without PC_PRED_BTB_EN, repeat REQ-032 -> second fetch at 0x20 still pred_taken=0, redirect again on resolution.
